// File: rtl/uart_row_sender.sv
// uart_row_sender: on a rising edge of i_send, streams one 16-character text
// row (optionally followed by CR LF) out of an 8N1 UART transmitter.
// Control characters in the row go out as spaces so that a terminal on the
// far end never sees stray escape or bell codes.
module uart_row_sender #(
    parameter int CLKS_PER_BIT = 234,
    parameter int APPEND_CRLF  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_send,
    input  logic [7:0] i_character,
    output logic [3:0] o_charIndex,
    output logic       o_TX_Serial,
    output logic       o_busy,
    output logic       o_done
);

    localparam int            CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    LAST_BYTE  = (APPEND_CRLF != 0) ? 5'd17 : 5'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t        state_q,    state_d;
    logic [1:0]    r_send_q,   r_send_d;
    logic [4:0]    byte_cnt_q, byte_cnt_d;
    logic [CW-1:0] clk_cnt_q,  clk_cnt_d;
    logic [2:0]    bit_idx_q,  bit_idx_d;
    logic [7:0]    shift_q,    shift_d;
    logic [3:0]    char_idx_q, char_idx_d;
    logic          tx_q,       tx_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;

    // Non-printable row characters (C0 controls and DEL) become a space.
    function automatic logic [7:0] sanitize_char(input logic [7:0] c);
        logic [7:0] r;
        if ((c < 8'h20) || (c == 8'h7F)) begin
            r = 8'h20;
        end else begin
            r = c;
        end
        return r;
    endfunction

    // Byte for a given position in the dump: row characters, then CR, LF.
    function automatic logic [7:0] select_byte(input logic [4:0] cnt, input logic [7:0] ch);
        logic [7:0] r;
        case (cnt)
            5'd16:   r = 8'h0D;
            5'd17:   r = 8'h0A;
            default: r = sanitize_char(ch);
        endcase
        return r;
    endfunction

    // Next-state and registered-output computation for the transmit FSM.
    always_comb begin
        state_d    = state_q;
        r_send_d   = {r_send_q[0], i_send};
        byte_cnt_d = byte_cnt_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        char_idx_d = char_idx_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (r_send_q == 2'b01) begin
                    state_d    = ST_LOAD;
                    byte_cnt_d = 5'd0;
                    char_idx_d = 4'd0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD: begin
                // i_character is only looked at in this single cycle.
                shift_d   = select_byte(byte_cnt_q, i_character);
                clk_cnt_d = {CW{1'b0}};
                bit_idx_d = 3'd0;
                tx_d      = 1'b0;
                state_d   = ST_START;
            end

            ST_START: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = {CW{1'b0}};
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            ST_DATA: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = {CW{1'b0}};
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            ST_STOP: begin
                tx_d = 1'b1;
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = {CW{1'b0}};
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        char_idx_d = 4'd0;
                    end else begin
                        // Counter stops at LAST_BYTE, so it never wraps.
                        byte_cnt_d = byte_cnt_q + 5'd1;
                        char_idx_d = byte_cnt_q[3:0] + 4'd1;
                        state_d    = ST_LOAD;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            ST_DONE: begin
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                char_idx_d = 4'd0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d    = ST_IDLE;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                char_idx_d = 4'd0;
                byte_cnt_d = 5'd0;
                clk_cnt_d  = {CW{1'b0}};
                bit_idx_d  = 3'd0;
            end
        endcase
    end

    // State and output registers; reset parks the line high and idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            r_send_q   <= 2'b00;
            byte_cnt_q <= 5'd0;
            clk_cnt_q  <= {CW{1'b0}};
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            char_idx_q <= 4'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_send_q   <= r_send_d;
            byte_cnt_q <= byte_cnt_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            char_idx_q <= char_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_charIndex = char_idx_q;
    assign o_TX_Serial = tx_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule
